// File: rtl/mcb_resp_pkg.sv
// rtl/mcb_resp_pkg.sv - shared types and widths for the MCB user port responder
package mcb_resp_pkg;

    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam int BL_W   = 6;
    localparam int ADDR_W = 30;

    typedef enum logic [2:0] {
        MCB_WR    = 3'b000,
        MCB_RD    = 3'b001,
        MCB_WR_AP = 3'b010,
        MCB_RD_AP = 3'b011,
        MCB_REF   = 3'b100
    } mcb_instr_e;

    typedef enum logic [2:0] {
        IDLE,
        LAT,
        WR,
        RD,
        REF
    } mcb_state_e;

    typedef struct packed {
        logic [2:0]        instr;
        logic [BL_W-1:0]   bl;
        logic [ADDR_W-1:0] addr;
    } mcb_cmd_t;

endpackage

// File: rtl/mcb_resp_fifo.sv
// rtl/mcb_resp_fifo.sv - synchronous first-word-fall-through FIFO with full/empty/count
module mcb_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    // Head reads as zero while empty so the output is defined out of reset.
    assign dout    = empty ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop_ok)  rptr_q <= rptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/mcb_user_port_responder.sv
// rtl/mcb_user_port_responder.sv - BRAM-backed responder for an MCB user port; MCB_RESP_STALL_EN adds LFSR back-pressure
module mcb_user_port_responder
    import mcb_resp_pkg::*;
#(
    parameter int MEM_WORDS_LOG2 = 10,
    parameter int CMD_LATENCY    = 4,
    parameter int CALIB_CYCLES   = 64,
    parameter int FIFO_DEPTH     = 64
) (
    input  logic              clk,
    input  logic              reset,
    output logic              calib_done,
    input  logic              cmd_en,
    input  logic [2:0]        cmd_instr,
    input  logic [BL_W-1:0]   cmd_bl,
    input  logic [ADDR_W-1:0] cmd_byte_addr,
    output logic              cmd_full,
    output logic              cmd_empty,
    input  logic              wr_en,
    input  logic [MASK_W-1:0] wr_mask,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic              wr_empty,
    output logic [6:0]        wr_count,
    output logic              wr_underrun,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_full,
    output logic              rd_empty,
    output logic [6:0]        rd_count,
    output logic [2:0]        err
);

    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam int CCW   = $clog2(CALIB_CYCLES + 1);
    localparam int CNT_W = 8;
    localparam int AW    = MEM_WORDS_LOG2;

    mcb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BL_W-1:0]     beats_q, beats_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [2:0]          instr_q, instr_d;
    logic                rd_vld_q;
    logic [CCW-1:0]      calib_cnt_q;
    logic                calib_done_q;
    logic [2:0]          err_q;

    mcb_cmd_t            cmd_in, cmd_head;
    logic                cmd_fifo_full, cmd_pop;
    logic [2:0]          cmd_count_unused;
    logic [DATA_W+MASK_W-1:0] wr_head;
    logic [FCW-1:0]      wr_cnt, rd_cnt;
    logic                wr_go, rd_go, rd_room, stall;
    logic [DATA_W-1:0]   mem [2**AW];
    logic [DATA_W-1:0]   bram_q;
    logic                unused_addr_bits;

    assign cmd_in           = '{instr: cmd_instr, bl: cmd_bl, addr: cmd_byte_addr};
    assign cmd_full         = cmd_fifo_full || !calib_done_q;
    assign calib_done       = calib_done_q;
    assign err              = err_q;
    assign wr_count         = 7'(wr_cnt);
    assign rd_count         = 7'(rd_cnt);
    assign rd_room          = (32'(rd_cnt) + 32'(rd_vld_q)) < FIFO_DEPTH;
    assign unused_addr_bits = ^{cmd_head.addr[ADDR_W-1:AW+2], cmd_head.addr[1:0]};

    mcb_resp_fifo #(.WIDTH($bits(mcb_cmd_t)), .DEPTH(4)) u_cmd_fifo (
        .clk(clk), .reset(reset), .push(cmd_en && !cmd_full), .pop(cmd_pop),
        .din(cmd_in), .dout(cmd_head), .full(cmd_fifo_full), .empty(cmd_empty),
        .count(cmd_count_unused)
    );

    mcb_resp_fifo #(.WIDTH(DATA_W+MASK_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk(clk), .reset(reset), .push(wr_en), .pop(wr_go),
        .din({wr_mask, wr_data}), .dout(wr_head), .full(wr_full), .empty(wr_empty),
        .count(wr_cnt)
    );

    mcb_resp_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk(clk), .reset(reset), .push(rd_vld_q), .pop(rd_en),
        .din(bram_q), .dout(rd_data), .full(rd_full), .empty(rd_empty),
        .count(rd_cnt)
    );

`ifdef MCB_RESP_STALL_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign stall = (lfsr_q[2:0] == 3'b000);
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            beats_q      <= '0;
            addr_q       <= '0;
            instr_q      <= 3'b000;
            rd_vld_q     <= 1'b0;
            calib_cnt_q  <= '0;
            calib_done_q <= 1'b0;
            err_q        <= 3'b000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            beats_q  <= beats_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            rd_vld_q <= rd_go;
            if (!calib_done_q) begin
                calib_cnt_q  <= calib_cnt_q + CCW'(1);
                calib_done_q <= (calib_cnt_q == CCW'(CALIB_CYCLES - 1));
            end
            err_q <= err_q | {rd_en && rd_empty, wr_en && wr_full, cmd_en && cmd_full};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        beats_d     = beats_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        cmd_pop     = 1'b0;
        wr_go       = 1'b0;
        rd_go       = 1'b0;
        wr_underrun = 1'b0;
        case (state_q)
            IDLE: if (!cmd_empty) begin
                cmd_pop = 1'b1;
                instr_d = cmd_head.instr;
                beats_d = cmd_head.bl;
                addr_d  = cmd_head.addr[AW+1:2];
                cnt_d   = CNT_W'(CMD_LATENCY - 1);
                state_d = LAT;
            end
            LAT: if (cnt_q == '0) begin
                case (instr_q)
                    MCB_WR, MCB_WR_AP: state_d = WR;
                    MCB_RD, MCB_RD_AP: state_d = RD;
                    MCB_REF: begin
                        state_d = REF;
                        cnt_d   = CNT_W'(7);
                    end
                    default: state_d = IDLE;
                endcase
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            WR: if (!stall) begin
                if (!wr_empty) begin
                    wr_go   = 1'b1;
                    addr_d  = addr_q + AW'(1);
                    beats_d = beats_q - BL_W'(1);
                    if (beats_q == '0) state_d = IDLE;
                end else begin
                    wr_underrun = 1'b1;
                end
            end
            // Room check includes the beat already in flight from BRAM.
            RD: if (!stall && rd_room) begin
                rd_go   = 1'b1;
                addr_d  = addr_q + AW'(1);
                beats_d = beats_q - BL_W'(1);
                if (beats_q == '0) state_d = IDLE;
            end
            REF: if (cnt_q == '0) state_d = IDLE;
                 else cnt_d = cnt_q - CNT_W'(1);
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_go) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!wr_head[DATA_W + b]) mem[addr_q][8*b +: 8] <= wr_head[8*b +: 8];
            end
        end
        if (rd_go) bram_q <= mem[addr_q];
    end

endmodule

// File: tb/tb_mcb_user_port_responder.sv
// tb/tb_mcb_user_port_responder.sv - self-checking bench for mcb_user_port_responder
module tb_mcb_user_port_responder;
    import mcb_resp_pkg::*;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        calib_done, cmd_en, cmd_full, cmd_empty;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        wr_en, wr_full, wr_empty, wr_underrun;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data, rd_data;
    logic [6:0]  wr_count, rd_count;
    logic        rd_en, rd_full, rd_empty;
    logic [2:0]  err;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [9:0]  waddr;
        logic [31:0] init;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[6];

    mcb_user_port_responder dut (
        .clk(clk), .reset(reset), .calib_done(calib_done),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
        .cmd_full(cmd_full), .cmd_empty(cmd_empty),
        .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data), .wr_full(wr_full), .wr_empty(wr_empty),
        .wr_count(wr_count), .wr_underrun(wr_underrun),
        .rd_en(rd_en), .rd_data(rd_data), .rd_full(rd_full), .rd_empty(rd_empty), .rd_count(rd_count),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr_word(input logic [31:0] d, input logic [3:0] m);
        wr_en = 1'b1; wr_data = d; wr_mask = m;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic issue_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] baddr);
        int n = 0;
        while (cmd_full && n < 300) begin @(negedge clk); n++; end
        check("cmd_ready", cmd_full, 0);
        cmd_en = 1'b1; cmd_instr = instr; cmd_bl = bl; cmd_byte_addr = baddr;
        @(negedge clk);
        cmd_en = 1'b0;
    endtask

    task automatic wait_wr_drain();
        int n = 0;
        while (!wr_empty && n < 300) begin @(negedge clk); n++; end
        check("wr_drain", wr_empty, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        logic [31:0] e;
        while (exp_q.size() > 0 && n < budget) begin
            if (!rd_empty) begin
                e = exp_q.pop_front();
                check("rd_data", rd_data, e);
                rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        rd_en = 1'b0;
        if (exp_q.size() > 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        int n;
        logic [29:0] ba;

        vecs[0] = '{10'h010, 32'hFFFF_FFFF, 32'h1234_5678, 4'b0101, 32'h12FF_56FF};
        vecs[1] = '{10'h020, 32'h0000_0000, 32'hDEAD_BEEF, 4'b0000, 32'hDEAD_BEEF};
        vecs[2] = '{10'h021, 32'hA5A5_A5A5, 32'h1234_5678, 4'b1111, 32'hA5A5_A5A5};
        vecs[3] = '{10'h022, 32'h0000_0000, 32'hCAFE_F00D, 4'b1010, 32'h00FE_000D};
        vecs[4] = '{10'h3FF, 32'h1111_1111, 32'h89AB_CDEF, 4'b0001, 32'h89AB_CD11};
        vecs[5] = '{10'h100, 32'h5A5A_5A5A, 32'h0000_0000, 4'b1000, 32'h5A00_0000};

        cmd_en = 0; cmd_instr = 0; cmd_bl = 0; cmd_byte_addr = 0;
        wr_en = 0; wr_mask = 0; wr_data = 0; rd_en = 0;

        // Reset state and calibration window
        repeat (3) @(negedge clk);
        check("rst_calib", calib_done, 0);
        check("rst_cmd_full", cmd_full, 1);
        check("rst_cmd_empty", cmd_empty, 1);
        check("rst_wr_empty", wr_empty, 1);
        check("rst_rd_empty", rd_empty, 1);
        check("rst_wr_full", wr_full, 0);
        check("rst_rd_full", rd_full, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_err", err, 0);
        check("rst_underrun", wr_underrun, 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        repeat (63) @(posedge clk);
        @(negedge clk);
        check("calib_63", calib_done, 0);
        check("cmd_full_63", cmd_full, 1);
        @(negedge clk);
        check("calib_64", calib_done, 1);
        check("cmd_full_64", cmd_full, 0);

        // Burst write then read with minimum-latency measurement
        for (int i = 0; i < 4; i++) wr_word(32'h11 * (i + 1), 4'b0000);
        issue_cmd(MCB_WR, 6'd3, 30'h40);
        wait_wr_drain();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h11 * (i + 1));
        issue_cmd(MCB_RD, 6'd3, 30'h40);
        n = 0;
        while (rd_empty && n < 30) begin @(negedge clk); n++; end
        check("rd_latency", n, L + 3);
        drain(60);

        // Masked single-word writes from the vector table
        for (int v = 0; v < 6; v++) begin
            ba = {18'h2A5A5, vecs[v].waddr, 2'b11};
            wr_word(vecs[v].init, 4'b0000);
            issue_cmd(MCB_WR, 6'd0, ba);
            wr_word(vecs[v].data, vecs[v].mask);
            issue_cmd(MCB_WR_AP, 6'd0, ba);
            exp_q.push_back(vecs[v].exp);
            issue_cmd(MCB_RD_AP, 6'd0, ba);
            drain(60);
        end

        // Fill the read FIFO to capacity, then drain in order
        for (int i = 0; i < 64; i++) wr_word(32'h5000_0000 + i * 32'h0001_0101, 4'b0000);
        check("wr_count_full", wr_count, 64);
        check("wr_full", wr_full, 1);
        issue_cmd(MCB_WR, 6'd63, 30'h800);
        wait_wr_drain();
        for (int i = 0; i < 64; i++) exp_q.push_back(32'h5000_0000 + i * 32'h0001_0101);
        issue_cmd(MCB_RD, 6'd63, 30'h800);
        n = 0;
        while (rd_count != 64 && n < 300) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        check("rd_count_full", rd_count, 64);
        check("rd_full", rd_full, 1);
        check("err_after_fill", err, 0);
        drain(400);
        check("rd_empty_after", rd_empty, 1);

        // Address wrap at the top of memory, behind a refresh
        wr_word(32'hA, 4'b0000);
        wr_word(32'hB, 4'b0000);
        issue_cmd(MCB_REF, 6'd0, 30'h0);
        issue_cmd(MCB_WR, 6'd1, 30'hFFC);
        exp_q.push_back(32'hA); exp_q.push_back(32'hB);
        issue_cmd(MCB_RD, 6'd1, 30'hFFC);
        drain(80);
        exp_q.push_back(32'hB);
        issue_cmd(MCB_RD, 6'd0, 30'h0);
        drain(60);

        // Read of an empty FIFO sets the sticky error
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        check("err_rd_empty", err, 3'b100);

        // Reset in the middle of a stalled write burst
        wr_word(32'h600D_0000, 4'b0000);
        wr_word(32'h600D_0001, 4'b0000);
        issue_cmd(MCB_WR, 6'd7, 30'h0);
        n = 0;
        while (!wr_empty && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        check("underrun", wr_underrun, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_calib", calib_done, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_underrun", wr_underrun, 0);
        check("mid_rst_empties", {cmd_empty, wr_empty, rd_empty}, 3'b111);
        check("mid_rst_cmd_full", cmd_full, 1);
        reset = 1'b0;
        n = 0;
        while (!calib_done && n < 100) begin @(negedge clk); n++; end
        check("recalib", calib_done, 1);
        exp_q.push_back(32'h600D_0000); exp_q.push_back(32'h600D_0001);
        issue_cmd(MCB_RD, 6'd1, 30'h0);
        drain(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
